decrementer: RTL and testbench
==============================

# decrementer

Synchronous loadable down-counter with asynchronous active-low clear to a preset value, 74163-style dual count enables, and a ripple-carry-out flag on terminal count zero. It serves as a cycle/event countdown (lives, timers, delays) in the game datapath. Parent logic normally gates `enp` with `~rco` so the count stops at zero.

## Interface
Parameters:
- `WIDTH`, 4, counter width in bits.
- `RESET_VALUE`, 3, value forced onto `Q` while `clr` is asserted; must fit in `WIDTH` bits.

Ports:
- `clock`  in  1  system clock; all synchronous activity on rising edge.
- `clr`  in  1  reset: one clock; reset is asynchronous and active-low. Forces `Q = RESET_VALUE`.
- `ld`  in  1  synchronous parallel load, active-high.
- `ent`  in  1  count enable T; also qualifies `rco`.
- `enp`  in  1  count enable P.
- `D`  in  `WIDTH`  parallel load data.
- `Q`  out  `WIDTH`  current count.
- `rco`  out  1  terminal-count flag, combinational.

## Operation
- Priority, highest first: `clr` low > `ld` high > count > hold.
- `clr` low: `Q` goes to `RESET_VALUE` immediately, independent of `clock`; held while low; all other inputs ignored.
- `ld` high at rising edge, `clr` high: `Q <= D`, regardless of `ent`/`enp`.
- `ent & enp` high, `ld` low: `Q <= Q - 1` modulo 2^WIDTH; 0 wraps to 2^WIDTH-1 (15 for WIDTH=4). The block does not saturate itself; stopping at zero is done by the parent gating `enp` with `~rco`.
- Otherwise `Q` holds.
- `rco = ent & (Q == 0)`, purely combinational from the registered `Q` and `ent`; independent of `enp`, `ld`, `D`.
- `rco` during reset: `ent & (RESET_VALUE == 0)`, so 0 with the default parameter.

## Timing
- `Q` is registered; a load or decrement is visible one cycle after the sampling edge.
- Clear is asynchronous on assertion; on deassertion the first counting edge is the first rising edge with `clr` high. Deassertion is synchronised externally.
- `rco` is valid in the same cycle `Q` reaches 0 when `ent` is high, and follows `ent` combinationally.
- With external gating `enp & ~rco`, from `Q = N` and `ent = enp = 1`, `Q` reaches 0 after N edges, then stays at 0 with `rco = 1`.
- A clear in the middle of counting aborts the count immediately. The next count starts from `RESET_VALUE`.
- `ld` and count enables asserted together: the load wins and no decrement occurs.

## Structure
- Shared package: default `WIDTH` and `RESET_VALUE` constants, so the parent and benches use the same preset.
- Single flat module: one `always` block with an asynchronous clear branch, plus a continuous assignment for `rco`. No sub-module is warranted.
- The RTL includes parameter legality checks (elaboration assertion that `RESET_VALUE < 2**WIDTH`). Simulation-only assertions check that the priority rules hold.

## Test plan
- Clear: hold `clr=0` for one period with `ent=enp=0` -> `Q=3`, `rco=0`. Release `clr` and hold for one period -> `Q` stays 3.
- Gated countdown: from `Q=3`, `ent=1`, `enp=1&~rco`, 4 periods -> `Q=0`, `rco=1`. Hold 5 more periods -> `Q=0`, `rco=1`.
- Wrap: ungated `enp=1`, `ent=1` from `Q=0`, one edge -> `Q=15`, `rco=0`. Another edge -> `Q=14`.
- Load priority: `ld=1`, `D=9`, `ent=enp=1`, one edge -> `Q=9` (not 8). Then `ld=0`, one edge -> `Q=8`.
- Enable qualification: `Q=0`, `ent=0` -> `rco=0`. `ent=1`, `enp=0` -> `rco=1` and `Q` holds across 3 edges.
- Asynchronous clear mid-count: `Q=12`, counting; assert `clr=0` between edges -> `Q=3` before the next edge. Release -> counting resumes 3, 2, 1, 0.

Source files
------------

// File: rtl/decrementer_pkg.sv
// Shared defaults for the game-datapath down-counter, so parent logic and
// benches agree on the width and the preset loaded by clear.
package decrementer_pkg;

    localparam int DEC_WIDTH       = 4;
    localparam int DEC_RESET_VALUE = 3;

endpackage

// File: rtl/decrementer.sv
// Loadable down-counter with async active-low clear to a preset, 74163-style
// dual count enables and a combinational terminal-count flag.
module decrementer
    import decrementer_pkg::*;
#(
    parameter int WIDTH       = DEC_WIDTH,
    parameter int RESET_VALUE = DEC_RESET_VALUE
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             ld,
    input  logic             ent,
    input  logic             enp,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco
);

    localparam logic [WIDTH-1:0] PRESET = WIDTH'(RESET_VALUE);

    if (RESET_VALUE < 0 || RESET_VALUE >= 2 ** WIDTH) begin : g_bad_reset_value
        $error("decrementer: RESET_VALUE %0d does not fit in %0d bits", RESET_VALUE, WIDTH);
    end

    // Load beats counting; wrap from 0 to all-ones is intentional, the parent
    // stops the count by gating enp with ~rco.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            Q <= PRESET;
        end else if (ld) begin
            Q <= D;
        end else if (ent && enp) begin
            Q <= Q - 1'b1;
        end
    end

    assign rco = ent && (Q == '0);

    a_load_wins : assert property (@(posedge clock) disable iff (!clr)
        ld |=> Q == $past(D));

    a_count : assert property (@(posedge clock) disable iff (!clr)
        (!ld && ent && enp) |=> Q == WIDTH'($past(Q) - 1'b1));

    a_hold : assert property (@(posedge clock) disable iff (!clr)
        (!ld && !(ent && enp)) |=> Q == $past(Q));

endmodule

// File: tb/tb_decrementer.sv
// Scoreboard bench for decrementer: a reference count model pushes expected
// values on each driven cycle; they are popped and compared after the edge.
module tb_decrementer;
    import decrementer_pkg::*;

    localparam int W = DEC_WIDTH;

    logic         clock = 1'b0;
    logic         clr   = 1'b1;
    logic         ld    = 1'b0;
    logic         ent   = 1'b0;
    logic         enp   = 1'b0;
    logic [W-1:0] D     = '0;
    logic [W-1:0] Q;
    logic         rco;

    logic [W-1:0] ref_q;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    decrementer #(.WIDTH(W), .RESET_VALUE(DEC_RESET_VALUE)) dut (
        .clock(clock),
        .clr  (clr),
        .ld   (ld),
        .ent  (ent),
        .enp  (enp),
        .D    (D),
        .Q    (Q),
        .rco  (rco)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_rco(input logic e_t);
        return e_t && (ref_q == '0);
    endfunction

    // One clock period: drive, update model, push expectation, pop after edge.
    task automatic cycle(input string tag, input logic l, input logic e_t,
                         input logic e_p, input logic [W-1:0] d);
        logic [W-1:0] want;
        ld  = l;
        ent = e_t;
        enp = e_p;
        D   = d;
        if (l)
            ref_q = d;
        else if (e_t && e_p)
            ref_q = ref_q - 1'b1;
        exp_q.push_back(ref_q);
        @(posedge clock);
        #1;
        want = exp_q.pop_front();
        check({tag, "_q"}, 32'(Q), 32'(want));
        check({tag, "_rco"}, 32'(rco), 32'(model_rco(ent)));
    endtask

    // Gated countdown: enp driven from the model's view of rco.
    task automatic gated(input string tag, input int n);
        for (int i = 0; i < n; i++)
            cycle(tag, 1'b0, 1'b1, !model_rco(1'b1), '0);
    endtask

    initial begin
        ref_q = W'(DEC_RESET_VALUE);
        #1 clr = 1'b0;
        @(posedge clock);
        #1;
        check("reset_q", 32'(Q), 32'(DEC_RESET_VALUE));
        check("reset_rco", 32'(rco), 32'(model_rco(ent)));
        clr = 1'b1;
        cycle("after_reset", 1'b0, 1'b0, 1'b0, '0);

        gated("gated", 4);
        check("gated_end_q", 32'(Q), 32'd0);
        gated("gated_hold", 5);

        cycle("wrap1", 1'b0, 1'b1, 1'b1, '0);
        check("wrap_q", 32'(Q), 32'((1 << W) - 1));
        cycle("wrap2", 1'b0, 1'b1, 1'b1, '0);

        cycle("load", 1'b1, 1'b1, 1'b1, W'(9));
        check("load_q", 32'(Q), 32'd9);
        cycle("load_next", 1'b0, 1'b1, 1'b1, W'(9));

        cycle("load_zero", 1'b1, 1'b0, 1'b0, '0);
        check("ent0_rco", 32'(rco), 32'd0);
        for (int i = 0; i < 3; i++)
            cycle("enp0_hold", 1'b0, 1'b1, 1'b0, W'(5));
        ent = 1'b0;
        #1;
        check("rco_follows_ent", 32'(rco), 32'(model_rco(ent)));

        cycle("load12", 1'b1, 1'b1, 1'b1, W'(12));
        cycle("count", 1'b0, 1'b1, 1'b1, '0);
        cycle("count", 1'b0, 1'b1, 1'b1, '0);
        #2 clr = 1'b0;
        ref_q = W'(DEC_RESET_VALUE);
        #1;
        check("async_clr_q", 32'(Q), 32'(DEC_RESET_VALUE));
        @(posedge clock);
        #1;
        check("clr_held_q", 32'(Q), 32'(DEC_RESET_VALUE));
        clr = 1'b1;
        gated("resume", 5);
        check("resume_end_q", 32'(Q), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
